fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register; the consumer of the stall (load_enable) and flush controls from the hazard detection unit.
- Owns the PC, issues requests to instruction memory over a req/ready handshake, and presents the fetched word to decode.
- Applies stalls by holding PC and IF/ID, and applies flushes by redirecting the PC and squashing IF/ID to a NOP.
- Drives a bubble request into the ID/EX register during load-use stalls.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction written into IF/ID on squash/bubble (MIPS sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- load_enable  input  1  0 = stall: hold PC and IF/ID.
- flush  input  1  1 = taken jump/branch resolved in ID; redirect.
- redirect_target  input  32  new PC, valid when flush=1.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, word aligned.
- imem_ready  input  1  response valid this cycle; completes handshake when imem_req=1.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- fd_instruction  output  32  IF/ID instruction.
- fd_pc_plus4  output  32  IF/ID PC+4 of fd_instruction.
- fd_valid  output  1  IF/ID holds a real instruction.
- dx_bubble  output  1  force ID/EX control signals to zero this cycle.

Behaviour:
- Reset (async):
  - pc=RESET_PC, state=RUN, pend_pc=0.
  - fd_instruction=NOP_WORD, fd_pc_plus4=0, fd_valid=0.
- Combinational outputs:
  - imem_req=1 whenever rst=0; imem_req=0 while rst=1.
  - dx_bubble = ~load_enable & fd_valid & ~flush.
- Handshake rule: while imem_req=1 and imem_ready=0, imem_addr is held constant. A bench checker flags any change.
- State RUN (imem_addr=pc), resolved on each rising edge, first match wins:
  1. flush & imem_ready: pc<=redirect_target; IF/ID<=NOP (fd_valid=0); fetched word dropped.
  2. flush & ~imem_ready: pend_pc<=redirect_target; state<=DISCARD; IF/ID<=NOP; pc held.
  3. ~load_enable: pc and IF/ID held. If imem_ready=1 the word is dropped and the same address is reissued next cycle.
  4. imem_ready: fd_instruction<=imem_rdata, fd_pc_plus4<=pc+4, fd_valid<=1, pc<=pc+4.
  5. else (memory wait, not stalled): pc held; IF/ID<=NOP, fd_valid<=0, because decode consumed its instruction.
- State DISCARD (imem_addr=pc, the old address; the in-flight fetch must complete):
  - IF/ID stays NOP; load_enable is ignored.
  - flush again: pend_pc<=redirect_target (newest wins).
  - imem_ready: the word is discarded; pc<=pend_pc (or redirect_target if flush is asserted that same cycle); state<=RUN.
- Precedence: flush overrides load_enable.
- Arithmetic: pc+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); no trap.
- redirect_target[1:0] is ignored and forced to 0.
- Reset mid-wait: state returns to RUN, the pending target is lost, and fetch restarts at RESET_PC.
- Latency: an instruction returned with ready in cycle N appears on fd_* after edge N. A flush in cycle N gives imem_addr=target in cycle N+1 (RUN with ready) or the cycle after the pending response (DISCARD).

Test Plan:
- Reset, imem_ready tied 1, rdata=addr|1 -> imem_addr 0,4,8,...; fd_pc_plus4 tracks addr+4, fd_valid=1 from second cycle.
- Steady fetch at pc=0x10, load_enable=0 for 2 cycles -> pc and fd_* frozen at 0x10/0x10 contents; dx_bubble=1 both cycles; resume fetches 0x10 then 0x14.
- flush=1, redirect_target=0x400, ready=1 -> next imem_addr=0x400; fd_instruction=0, fd_valid=0 for one cycle; next fd_pc_plus4=0x404.
- ready=0 at pc=0x20, flush with target 0x80, ready held 0 for 3 cycles, then second flush target 0xC0, then ready=1 -> imem_addr stays 0x20 throughout, then 0xC0; the 0x20 word is never presented on fd_*.
- flush and load_enable=0 in same cycle -> redirect taken, dx_bubble=0, IF/ID NOP.
- pc=0xFFFF_FFFC with ready=1 -> next imem_addr=0x0, fd_pc_plus4=0x0. Async rst during a DISCARD wait -> fd_valid=0 immediately, imem_addr=RESET_PC after release.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, imem req/ready handshake and IF/ID register.
// Stalls hold PC and IF/ID; flushes redirect the PC and squash IF/ID to a NOP.
// A flush raised while a fetch is still outstanding parks the target in
// pend_pc until that fetch completes, so imem_addr never changes mid-handshake.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_enable,
  input  logic        flush,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fd_instruction,
  output logic [31:0] fd_pc_plus4,
  output logic        fd_valid,
  output logic        dx_bubble
);

  // state | meaning
  // RUN     | normal fetch at pc
  // DISCARD | flushed while a fetch was outstanding; drop that word, then jump to pend_pc
  typedef enum logic {RUN, DISCARD} state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] pend_pc, pend_pc_nx;
  logic [31:0] ins_nx, pc4_nx;
  logic        valid_nx;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Fetch addresses are word aligned, so the low target bits are dropped.
  assign target   = redirect_target & 32'hFFFF_FFFC;
  assign pc_plus4 = pc + 32'd4;

  assign imem_req  = ~rst;
  assign imem_addr = pc;
  assign dx_bubble = ~load_enable & fd_valid & ~flush;

  // State, PC, pending target and IF/ID registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      pend_pc        <= 32'h0000_0000;
      fd_instruction <= NOP_WORD;
      fd_pc_plus4    <= 32'h0000_0000;
      fd_valid       <= 1'b0;
    end else begin
      state          <= state_nx;
      pc             <= pc_nx;
      pend_pc        <= pend_pc_nx;
      fd_instruction <= ins_nx;
      fd_pc_plus4    <= pc4_nx;
      fd_valid       <= valid_nx;
    end
  end

  // Next-state and next IF/ID contents; flush is tested before load_enable.
  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    pend_pc_nx = pend_pc;
    ins_nx     = fd_instruction;
    pc4_nx     = fd_pc_plus4;
    valid_nx   = fd_valid;
    case (state)
      RUN: begin
        if (flush && imem_ready) begin
          pc_nx    = target;
          ins_nx   = NOP_WORD;
          pc4_nx   = 32'h0000_0000;
          valid_nx = 1'b0;
        end else if (flush) begin
          pend_pc_nx = target;
          state_nx   = DISCARD;
          ins_nx     = NOP_WORD;
          pc4_nx     = 32'h0000_0000;
          valid_nx   = 1'b0;
        end else if (!load_enable) begin
          // Stall: any returned word is dropped and the same pc is reissued.
        end else if (imem_ready) begin
          ins_nx   = imem_rdata;
          pc4_nx   = pc_plus4;
          valid_nx = 1'b1;
          pc_nx    = pc_plus4;
        end else begin
          // Decode consumed the previous instruction; nothing new to give it.
          ins_nx   = NOP_WORD;
          pc4_nx   = 32'h0000_0000;
          valid_nx = 1'b0;
        end
      end
      DISCARD: begin
        ins_nx   = NOP_WORD;
        pc4_nx   = 32'h0000_0000;
        valid_nx = 1'b0;
        if (imem_ready) begin
          pc_nx    = flush ? target : pend_pc;
          state_nx = RUN;
        end else if (flush) begin
          pend_pc_nx = target;
        end
      end
      default: begin
        state_nx = RUN;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: one table of per-cycle vectors plus
// hand-written async-reset sequences and a handshake-stability monitor.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        load_enable;
  logic        flush;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] fd_instruction;
  logic [31:0] fd_pc_plus4;
  logic        fd_valid;
  logic        dx_bubble;

  int n_total = 0;
  int n_pass  = 0;

  fetch_stage dut (
    .clk(clk),
    .rst(rst),
    .load_enable(load_enable),
    .flush(flush),
    .redirect_target(redirect_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .fd_instruction(fd_instruction),
    .fd_pc_plus4(fd_pc_plus4),
    .fd_valid(fd_valid),
    .dx_bubble(dx_bubble)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        le;
    logic        fl;
    logic [31:0] tgt;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] addr;   // imem_addr before the edge
    logic        bub;    // dx_bubble before the edge
    logic [31:0] ins;    // fd_instruction after the edge
    logic [31:0] pc4;    // fd_pc_plus4 after the edge (checked only when valid)
    logic        val;    // fd_valid after the edge
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Handshake monitor: address must not move while a request is waiting.
  logic        hold_pending;
  logic [31:0] held_addr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_pending <= 1'b0;
    end else begin
      if (hold_pending) begin
        n_total++;
        if (imem_addr === held_addr) n_pass++;
        else $display("FAIL addr_hold: got %h expected %h at %0t", imem_addr, held_addr, $time);
      end
      hold_pending <= imem_req & ~imem_ready;
      held_addr    <= imem_addr;
    end
  end

  initial begin
    //                le  fl  tgt            rdy rdata          addr           bub ins            pc4            val
    vq.push_back('{1, 0, 32'h0,         1, 32'h1,         32'h0,         0, 32'h1,         32'h4,         1});
    vq.push_back('{1, 0, 32'h0,         1, 32'h5,         32'h4,         0, 32'h5,         32'h8,         1});
    vq.push_back('{1, 0, 32'h0,         1, 32'h9,         32'h8,         0, 32'h9,         32'hC,         1});
    vq.push_back('{1, 0, 32'h0,         1, 32'hD,         32'hC,         0, 32'hD,         32'h10,        1});
    vq.push_back('{0, 0, 32'h0,         1, 32'h11,        32'h10,        1, 32'hD,         32'h10,        1});
    vq.push_back('{0, 0, 32'h0,         1, 32'h11,        32'h10,        1, 32'hD,         32'h10,        1});
    vq.push_back('{1, 0, 32'h0,         1, 32'h11,        32'h10,        0, 32'h11,        32'h14,        1});
    vq.push_back('{1, 0, 32'h0,         1, 32'h15,        32'h14,        0, 32'h15,        32'h18,        1});
    vq.push_back('{1, 1, 32'h400,       1, 32'h19,        32'h18,        0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 0, 32'h0,         1, 32'h401,       32'h400,       0, 32'h401,       32'h404,       1});
    vq.push_back('{0, 1, 32'h803,       1, 32'h405,       32'h404,       0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 0, 32'h0,         1, 32'h801,       32'h800,       0, 32'h801,       32'h804,       1});
    vq.push_back('{1, 0, 32'h0,         0, 32'hBAD,       32'h804,       0, 32'h0,         32'h0,         0});
    vq.push_back('{0, 0, 32'h0,         0, 32'hBAD,       32'h804,       0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 0, 32'h0,         1, 32'h805,       32'h804,       0, 32'h805,       32'h808,       1});
    vq.push_back('{1, 1, 32'h20,        1, 32'h809,       32'h808,       0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 1, 32'h80,        0, 32'hBAD,       32'h20,        0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 0, 32'h0,         0, 32'hBAD,       32'h20,        0, 32'h0,         32'h0,         0});
    vq.push_back('{0, 0, 32'h0,         0, 32'hBAD,       32'h20,        0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 1, 32'hC0,        0, 32'hBAD,       32'h20,        0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 0, 32'h0,         1, 32'h21,        32'h20,        0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 0, 32'h0,         1, 32'hC1,        32'hC0,        0, 32'hC1,        32'hC4,        1});
    vq.push_back('{1, 1, 32'h100,       0, 32'hBAD,       32'hC4,        0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 1, 32'h200,       1, 32'hC5,        32'hC4,        0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 0, 32'h0,         1, 32'h201,       32'h200,       0, 32'h201,       32'h204,       1});
    vq.push_back('{1, 1, 32'hFFFF_FFFC, 1, 32'h205,       32'h204,       0, 32'h0,         32'h0,         0});
    vq.push_back('{1, 0, 32'h0,         1, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFD, 32'h0,         1});
    vq.push_back('{1, 0, 32'h0,         1, 32'h1,         32'h0,         0, 32'h1,         32'h4,         1});
    vq.push_back('{0, 0, 32'h0,         0, 32'hBAD,       32'h4,         1, 32'h1,         32'h4,         1});

    rst = 1'b0;
    load_enable = 1'b1;
    flush = 1'b0;
    redirect_target = 32'h0;
    imem_ready = 1'b0;
    imem_rdata = 32'h0;
    #1 rst = 1'b1;
    #1;
    chk("reset_req", {31'h0, imem_req}, 32'h0);
    chk("reset_valid", {31'h0, fd_valid}, 32'h0);
    chk("reset_ins", fd_instruction, 32'h0);
    chk("reset_pc4", fd_pc_plus4, 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("release_req", {31'h0, imem_req}, 32'h1);
    chk("release_addr", imem_addr, 32'h0);

    foreach (vq[i]) begin
      load_enable     = vq[i].le;
      flush           = vq[i].fl;
      redirect_target = vq[i].tgt;
      imem_ready      = vq[i].rdy;
      imem_rdata      = vq[i].rdata;
      #1;
      chk($sformatf("v%0d_addr", i), imem_addr, vq[i].addr);
      chk($sformatf("v%0d_bubble", i), {31'h0, dx_bubble}, {31'h0, vq[i].bub});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'h0, fd_valid}, {31'h0, vq[i].val});
      chk($sformatf("v%0d_ins", i), fd_instruction, vq[i].ins);
      if (vq[i].val) chk($sformatf("v%0d_pc4", i), fd_pc_plus4, vq[i].pc4);
    end

    // Async reset between edges while IF/ID holds a real instruction.
    rst = 1'b1;
    #1;
    chk("async_valid", {31'h0, fd_valid}, 32'h0);
    chk("async_ins", fd_instruction, 32'h0);
    chk("async_req", {31'h0, imem_req}, 32'h0);
    rst = 1'b0;
    #1;
    chk("async_addr", imem_addr, 32'h0);

    // Enter DISCARD, then reset mid-wait: pending target must be forgotten.
    load_enable = 1'b1;
    flush = 1'b1;
    redirect_target = 32'h300;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    redirect_target = 32'h0;
    @(posedge clk); #2;
    chk("discard_addr", imem_addr, 32'h0);
    rst = 1'b1;
    #1;
    chk("discard_rst_valid", {31'h0, fd_valid}, 32'h0);
    rst = 1'b0;
    #1;
    chk("discard_rst_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    chk("after_rst_ins", fd_instruction, 32'h1234_5678);
    chk("after_rst_pc4", fd_pc_plus4, 32'h4);
    chk("after_rst_valid", {31'h0, fd_valid}, 32'h1);
    chk("after_rst_addr", imem_addr, 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
